// File: rtl/music_note_seq.sv
// music_note_seq: FIFO-fed note sequencer driving the music playback block's note bus.
// Optional replay mode (re-enqueue every popped note) is built with `define MUSIC_SEQ_LOOP_EN.
module music_note_seq #(
  parameter int DEPTH      = 16,
  parameter int BEAT_DIV   = 25000000,
  parameter int GAP_CYCLES = 2500000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   musiccs,
  input  logic                   wr_en,
  input  logic [15:0]            wr_data,
  input  logic                   flush,
  input  logic                   loop,
  output logic [4:0]             music_data,
  output logic                   music_uart_enable,
  output logic                   fifo_full,
  output logic                   fifo_empty,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   overflow,
  output logic                   busy
);

  // state | meaning
  // IDLE  | bus released, silent, waiting for a queued note
  // PLAY  | driving note_q until beats_q beats have elapsed
  // GAP   | silent spacing between notes, bus still owned

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = (BEAT_DIV > 1) ? $clog2(BEAT_DIV) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [TW-1:0] TICK_LOAD = TW'(BEAT_DIV - 1);
  localparam logic [GW-1:0] GAP_LOAD  = GW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [9:0]      mem [DEPTH];
  logic [AW-1:0]   rd_ptr, wr_ptr;
  logic [CW-1:0]   count_q;
  logic            overflow_q;
  logic [4:0]      note_q, beats_q;
  logic [TW-1:0]   tick_q;
  logic [GW-1:0]   gap_q;

  logic [9:0]      head;
  logic [4:0]      head_beats;
  logic            pop, push, wr_accept, wr_drop, ext_wr;
  logic [9:0]      push_word;
  logic            playing, gapping;
  logic            unused_bits;

  // Stored word is {duration, note}; unused bus bits are not kept.
  assign head       = mem[rd_ptr];
  assign head_beats = (head[9:5] == 5'd0) ? 5'd1 : head[9:5];
  assign ext_wr     = wr_en & musiccs;

  assign fifo_count = count_q;
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CW'(DEPTH));
  assign overflow   = overflow_q;
  assign busy       = (state_q != IDLE);

  assign unused_bits = ^{wr_data[15:13], wr_data[7:5], loop};

`ifdef MUSIC_SEQ_LOOP_EN
  logic reenq;
  // In replay mode the popped head goes straight back to the tail.
  assign reenq     = loop & pop;
  assign wr_accept = ext_wr & ~loop & (~fifo_full | pop);
  assign push      = wr_accept | reenq;
  assign push_word = reenq ? head : {wr_data[12:8], wr_data[4:0]};
`else
  assign wr_accept = ext_wr & (~fifo_full | pop);
  assign push      = wr_accept;
  assign push_word = {wr_data[12:8], wr_data[4:0]};
`endif

  assign wr_drop = ext_wr & ~wr_accept;

  always_comb begin
    state_d           = state_q;
    pop               = 1'b0;
    music_data        = 5'd0;
    music_uart_enable = 1'b0;
    case (state_q)
      IDLE: begin
        if (musiccs && !fifo_empty) begin
          pop     = 1'b1;
          state_d = PLAY;
        end
      end
      PLAY: begin
        music_uart_enable = 1'b1;
        if (musiccs) begin
          music_data = note_q;
          if (tick_q == '0 && beats_q == 5'd1) state_d = GAP;
        end
      end
      GAP: begin
        music_uart_enable = 1'b1;
        if (musiccs && gap_q == '0) begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            state_d = PLAY;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d = IDLE;
      pop     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
      if (wr_drop) overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && !flush && push) mem[wr_ptr] <= push_word;
  end

  assign playing = (state_q == PLAY) && musiccs && !flush;
  assign gapping = (state_q == GAP) && musiccs && !flush;

  // Beat and gap timers are down-counters; terminal count is zero.
  always_ff @(posedge clk) begin
    if (!rst) begin
      note_q  <= 5'd0;
      beats_q <= 5'd0;
      tick_q  <= '0;
      gap_q   <= '0;
    end else if (pop) begin
      note_q  <= head[4:0];
      beats_q <= head_beats;
      tick_q  <= TICK_LOAD;
    end else if (playing) begin
      if (tick_q == '0) begin
        tick_q  <= TICK_LOAD;
        beats_q <= beats_q - 5'd1;
        if (beats_q == 5'd1) gap_q <= GAP_LOAD;
      end else begin
        tick_q <= tick_q - 1'b1;
      end
    end else if (gapping && gap_q != '0) begin
      gap_q <= gap_q - 1'b1;
    end
  end

endmodule

// File: tb/tb_music_note_seq.sv
// Bench for music_note_seq: cycle table for status/priority behaviour, plus a
// note-run scoreboard for timing of notes, gaps, pause and (optionally) replay.
module tb_music_note_seq;
  localparam int DEPTH      = 4;
  localparam int BEAT_DIV   = 4;
  localparam int GAP_CYCLES = 2;

  logic        clk = 1'b0;
  logic        rst, musiccs, wr_en, flush, loop;
  logic [15:0] wr_data;
  logic [4:0]  music_data;
  logic        music_uart_enable, fifo_full, fifo_empty, overflow, busy;
  logic [2:0]  fifo_count;

  always #5 clk = ~clk;

  music_note_seq #(.DEPTH(DEPTH), .BEAT_DIV(BEAT_DIV), .GAP_CYCLES(GAP_CYCLES)) dut (
    .clk(clk), .rst(rst), .musiccs(musiccs), .wr_en(wr_en), .wr_data(wr_data),
    .flush(flush), .loop(loop), .music_data(music_data),
    .music_uart_enable(music_uart_enable), .fifo_full(fifo_full),
    .fifo_empty(fifo_empty), .fifo_count(fifo_count), .overflow(overflow), .busy(busy)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct { int note; int len; } run_t;
  run_t sb_q[$];
  bit   mon_en;
  int   run_note, run_len, gap_len;

  typedef struct {
    bit r, cs, wr, fl;
    logic [15:0] d;
    int cnt, full, empty, ovf, bsy, md, en;
  } vec_t;
  vec_t vt[$];

  function automatic void check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endfunction

  function automatic void exp_run(input int note, input int len);
    run_t e;
    e.note = note;
    e.len  = len;
    sb_q.push_back(e);
  endfunction

  function automatic void close_run();
    run_t e;
    if (sb_q.size() == 0) begin
      check("unexpected_note", run_note, 0);
    end else begin
      e = sb_q.pop_front();
      check("note_code", run_note, e.note);
      check("note_len", run_len, e.len);
    end
    run_len = 0;
  endfunction

  // Advance one cycle; sample on the falling edge and track note/gap runs.
  task automatic step();
    @(negedge clk);
    if (mon_en && musiccs) begin
      if (music_data != 5'd0) begin
        if (gap_len > 0) begin
          check("gap_len", gap_len, GAP_CYCLES);
          gap_len = 0;
        end
        if (run_len > 0 && int'(music_data) != run_note) close_run();
        run_note = int'(music_data);
        run_len++;
      end else begin
        if (run_len > 0) close_run();
        if (music_uart_enable) gap_len++;
        else if (gap_len > 0) begin
          check("gap_len", gap_len, GAP_CYCLES);
          gap_len = 0;
        end
      end
    end
  endtask

  task automatic write(input logic [15:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    step();
    wr_en   = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int k;
    k = 0;
    while (!busy && k < 20) begin step(); k++; end
    k = 0;
    while (busy && k < 400) begin step(); k++; end
    check({name, "_busy_timeout"}, int'(busy), 0);
    check({name, "_enable_idle"}, int'(music_uart_enable), 0);
    check({name, "_data_idle"}, int'(music_data), 0);
    check({name, "_runs_left"}, sb_q.size(), 0);
    check({name, "_empty"}, int'(fifo_empty), 1);
  endtask

  function automatic void v(input bit r, input bit cs, input bit wr, input bit fl,
                            input logic [15:0] d, input int cnt, input int full,
                            input int empty, input int ovf, input int bsy,
                            input int md, input int en);
    vt.push_back('{r, cs, wr, fl, d, cnt, full, empty, ovf, bsy, md, en});
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; musiccs = 1'b0; wr_en = 1'b0; wr_data = '0; flush = 1'b0; loop = 1'b0;
    mon_en = 1'b0; run_note = 0; run_len = 0; gap_len = 0;

    //  r  cs wr fl data      cnt f e ov b md en
    v(0, 0, 0, 0, 16'h0000, 0, 0, 1, 0, 0, 0, 0);
    v(0, 0, 0, 0, 16'h0000, 0, 0, 1, 0, 0, 0, 0);
    v(0, 0, 0, 0, 16'h0000, 0, 0, 1, 0, 0, 0, 0);
    v(1, 1, 0, 0, 16'h0000, 0, 0, 1, 0, 0, 0, 0);
    v(1, 1, 1, 0, 16'h1F01, 1, 0, 0, 0, 0, 0, 0);
    v(1, 1, 1, 0, 16'h0002, 1, 0, 0, 0, 1, 1, 1);
    v(1, 1, 1, 0, 16'h0003, 2, 0, 0, 0, 1, 1, 1);
    v(1, 1, 1, 0, 16'h0004, 3, 0, 0, 0, 1, 1, 1);
    v(1, 1, 1, 0, 16'h0005, 4, 1, 0, 0, 1, 1, 1);
    v(1, 1, 1, 0, 16'h0006, 4, 1, 0, 1, 1, 1, 1);
    v(1, 1, 0, 0, 16'h0000, 4, 1, 0, 1, 1, 1, 1);
    v(1, 1, 1, 1, 16'h0008, 0, 0, 1, 0, 0, 0, 0);
    v(1, 1, 0, 0, 16'h0000, 0, 0, 1, 0, 0, 0, 0);
    v(1, 1, 1, 0, 16'h0209, 1, 0, 0, 0, 0, 0, 0);
    v(1, 1, 0, 0, 16'h0000, 0, 0, 1, 0, 1, 9, 1);
    v(0, 1, 0, 0, 16'h0000, 0, 0, 1, 0, 0, 0, 0);
    v(1, 1, 0, 0, 16'h0000, 0, 0, 1, 0, 0, 0, 0);
    v(1, 1, 1, 0, 16'h0001, 1, 0, 0, 0, 0, 0, 0);
    v(1, 1, 1, 0, 16'h0102, 1, 0, 0, 0, 1, 1, 1);
    v(1, 1, 1, 0, 16'h0103, 2, 0, 0, 0, 1, 1, 1);
    v(1, 1, 1, 0, 16'h0104, 3, 0, 0, 0, 1, 1, 1);
    v(1, 1, 1, 0, 16'h0105, 4, 1, 0, 0, 1, 1, 1);
    v(1, 1, 0, 0, 16'h0000, 4, 1, 0, 0, 1, 0, 1);
    v(1, 1, 0, 0, 16'h0000, 4, 1, 0, 0, 1, 0, 1);
    v(1, 1, 1, 0, 16'h0106, 4, 1, 0, 0, 1, 2, 1);
    v(1, 1, 0, 1, 16'h0000, 0, 0, 1, 0, 0, 0, 0);

    foreach (vt[i]) begin
      rst = vt[i].r; musiccs = vt[i].cs; wr_en = vt[i].wr; flush = vt[i].fl; wr_data = vt[i].d;
      step();
      check($sformatf("v%0d_count", i),    int'(fifo_count),        vt[i].cnt);
      check($sformatf("v%0d_full", i),     int'(fifo_full),         vt[i].full);
      check($sformatf("v%0d_empty", i),    int'(fifo_empty),        vt[i].empty);
      check($sformatf("v%0d_overflow", i), int'(overflow),          vt[i].ovf);
      check($sformatf("v%0d_busy", i),     int'(busy),              vt[i].bsy);
      check($sformatf("v%0d_data", i),     int'(music_data),        vt[i].md);
      check($sformatf("v%0d_enable", i),   int'(music_uart_enable), vt[i].en);
    end
    rst = 1'b1; musiccs = 1'b1; wr_en = 1'b0; flush = 1'b0;
    step();

    mon_en = 1'b1;
    exp_run(5, 8);
    exp_run(3, 4);
    write(16'h0205);
    write(16'h0103);
    wait_done("two_note");

    exp_run(7, 4);
    write(16'h0007);
    wait_done("zero_dur");

    exp_run(9, 8);
    write(16'h0209);
    for (int k = 0; k < 4; k++) step();
    musiccs = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      check("pause_data", int'(music_data), 0);
      check("pause_busy", int'(busy), 1);
    end
    musiccs = 1'b1;
    wait_done("pause");

`ifdef MUSIC_SEQ_LOOP_EN
    exp_run(1, 4);
    for (int k = 0; k < 3; k++) begin
      exp_run(2, 4);
      exp_run(3, 4);
    end
    write(16'h0001);
    write(16'h0002);
    write(16'h0003);
    loop = 1'b1;
    begin
      int k;
      k = 0;
      while (sb_q.size() > 0 && k < 300) begin
        step();
        check("loop_count", int'(fifo_count), 2);
        k++;
      end
      check("loop_runs_left", sb_q.size(), 0);
    end
    write(16'h0004);
    check("loop_wr_overflow", int'(overflow), 1);
    check("loop_wr_count", int'(fifo_count), 2);
    mon_en = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    loop  = 1'b0;
    run_len = 0;
    gap_len = 0;
    sb_q.delete();
    step();
    check("loop_flush_count", int'(fifo_count), 0);
    check("loop_flush_overflow", int'(overflow), 0);
    check("loop_flush_busy", int'(busy), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
